// File: rtl/ps2_pkg.sv
// +---------------------------------------------------------------------------+
// | ps2_pkg : byte constants, key map and parser state for ps2_key_ctrl      |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] c_e0 = 8'hE0;
  localparam logic [7:0] c_f0 = 8'hF0;
  localparam logic [7:0] c_e1 = 8'hE1;
  localparam logic [7:0] c_00 = 8'h00;
  localparam logic [7:0] c_aa = 8'hAA;
  localparam logic [7:0] c_fa = 8'hFA;
  localparam logic [7:0] c_fe = 8'hFE;
  localparam logic [7:0] c_ff = 8'hFF;
  localparam logic [7:0] c_12 = 8'h12;

  // Key map entries are {ext, code}
  localparam logic [8:0] c_key_up    = {1'b1, 8'h75};
  localparam logic [8:0] c_key_down  = {1'b1, 8'h72};
  localparam logic [8:0] c_key_left  = {1'b1, 8'h6B};
  localparam logic [8:0] c_key_right = {1'b1, 8'h74};
  localparam logic [8:0] c_key_fire  = {1'b0, 8'h29};
  localparam logic [8:0] c_key_start = {1'b0, 8'h5A};
  localparam logic [8:0] c_key_coin  = {1'b0, 8'h2E};
  localparam logic [8:0] c_key_pause = {1'b0, 8'h4D};

  localparam int c_idx_up    = 0;
  localparam int c_idx_down  = 1;
  localparam int c_idx_left  = 2;
  localparam int c_idx_right = 3;
  localparam int c_idx_fire  = 4;
  localparam int c_idx_start = 5;
  localparam int c_idx_coin  = 6;
  localparam int c_idx_pause = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } ps2_state_t;

  function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] code);
    logic [8:0] k;
    k = {ext, code};
    key_mask = '0;
    key_mask[c_idx_up]    = (k == c_key_up);
    key_mask[c_idx_down]  = (k == c_key_down);
    key_mask[c_idx_left]  = (k == c_key_left);
    key_mask[c_idx_right] = (k == c_key_right);
    key_mask[c_idx_fire]  = (k == c_key_fire);
    key_mask[c_idx_start] = (k == c_key_start);
    key_mask[c_idx_coin]  = (k == c_key_coin);
    key_mask[c_idx_pause] = (k == c_key_pause);
  endfunction

  // Status/ack bytes from the device that never represent a key
  function automatic logic is_status(input logic [7:0] code);
    is_status = (code == c_00) || (code == c_aa) || (code == c_fa) ||
                (code == c_fe) || (code == c_ff);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
// +---------------------------------------------------------------------------+
// | ps2_evt_fifo : synchronous first-word-fall-through event queue           |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module ps2_evt_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full_cnt = CW'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             pop;
  logic             push;

  assign full     = (count == c_full_cnt);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  // A pop on a full queue frees the slot the incoming write needs
  assign push     = wr_req & (~full | pop);
  assign drop     = wr_req & full & ~pop;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
// +---------------------------------------------------------------------------+
// | ps2_key_ctrl : PS/2 scancode sequencer, event queue and held-key vector  |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 50000,
  parameter int E1_SKIP    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] keys,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(E1_SKIP + 1);
  localparam logic [TW-1:0] c_to_last   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] c_skip_init = SW'(E1_SKIP);
  localparam logic [SW-1:0] c_skip_one  = SW'(1);

  ps2_state_t    state;
  ps2_state_t    state_n;
  logic          valid_d;
  logic          byte_stb;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] skip_cnt;
  logic [SW-1:0] skip_n;
  logic          emit;
  logic          emit_ext;
  logic          emit_brk;
  logic [7:0]    mask;
  logic [9:0]    head;
  logic          drop;

  assign byte_stb = valid & ~valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      valid_d  <= 1'b0;
      to_cnt   <= '0;
      skip_cnt <= '0;
    end else begin
      state    <= state_n;
      valid_d  <= valid;
      skip_cnt <= skip_n;
      if (byte_stb || state == ST_IDLE) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // A strobe takes precedence over the timeout so a late byte is never lost
  always_comb begin
    state_n  = state;
    skip_n   = skip_cnt;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (byte_stb) begin
      case (state)
        ST_IDLE: begin
          if (code == c_e0) begin
            state_n = ST_EXT;
          end else if (code == c_f0) begin
            state_n = ST_BRK;
          end else if (code == c_e1) begin
            state_n = ST_SKIP;
            skip_n  = c_skip_init;
          end else if (!is_status(code)) begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (code == c_f0) begin
            state_n = ST_EXT_BRK;
          end else if (code != c_e0 && code != c_12) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_n  = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit     = 1'b1;
          emit_brk = 1'b1;
          state_n  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (code != c_12) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
          state_n = ST_IDLE;
        end
        ST_SKIP: begin
          skip_n = skip_cnt - 1'b1;
          if (skip_cnt == c_skip_one) begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && to_cnt == c_to_last) begin
      state_n = ST_IDLE;
    end
  end

  assign mask = key_mask(emit_ext, code);

  always_ff @(posedge clk) begin
    if (rst) begin
      keys     <= '0;
      overflow <= 1'b0;
    end else begin
      if (emit) begin
        keys <= emit_brk ? (keys & ~mask) : (keys | mask);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  ps2_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (10)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (emit),
    .wr_data  ({code, emit_ext, emit_brk}),
    .rd_ready (ev_ready),
    .rd_data  (head),
    .rd_valid (ev_valid),
    .drop     (drop)
  );

  assign ev_code = head[9:2];
  assign ev_ext  = head[1];
  assign ev_brk  = head[0];

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_ps2_key_ctrl : directed self-checking bench for ps2_key_ctrl          |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_ps2_key_ctrl;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code;
  logic       valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] keys;
  logic       overflow;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;
  logic [9:0] got_q [$];

  ps2_key_ctrl #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (TO),
    .E1_SKIP    (7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .code     (code),
    .valid    (valid),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .keys     (keys),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Record every accepted event; inputs only change just after posedge
  always @(negedge clk) begin
    if (ev_valid && ev_ready) got_q.push_back({ev_code, ev_ext, ev_brk});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    code  = b;
    valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
  endtask

  task automatic test_reset();
    code = 8'h00; valid = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_ev_valid got=%b want=0", ev_valid); end
    total++; if ({ev_code, ev_ext, ev_brk} !== 10'h000) begin bad++; $display("FAIL reset_head got=%h want=000", {ev_code, ev_ext, ev_brk}); end
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL reset_keys got=%h want=00", keys); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_press_release();
    ev_ready = 1'b1;
    got_q.delete();
    send(8'h29);
    settle();
    total++; if (got_q.size() != 1 || got_q[0] !== {8'h29, 2'b00}) begin bad++; $display("FAIL press_event n=%0d got=%h want=0a4", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h3ff); end
    total++; if (keys !== 8'h10) begin bad++; $display("FAIL press_keys got=%h want=10", keys); end
    send(8'hF0); send(8'h29);
    settle();
    total++; if (got_q.size() != 2 || got_q[1] !== {8'h29, 2'b01}) begin bad++; $display("FAIL release_event n=%0d want=0a5", got_q.size()); end
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL release_keys got=%h want=00", keys); end
  endtask

  task automatic test_extended();
    got_q.delete();
    send(8'hE0); send(8'h75);
    settle();
    total++; if (got_q.size() != 1 || got_q[0] !== {8'h75, 2'b10}) begin bad++; $display("FAIL ext_press n=%0d want=1d6", got_q.size()); end
    total++; if (keys !== 8'h01) begin bad++; $display("FAIL ext_press_keys got=%h want=01", keys); end
    send(8'hE0); send(8'hF0); send(8'h75);
    settle();
    total++; if (got_q.size() != 2 || got_q[1] !== {8'h75, 2'b11}) begin bad++; $display("FAIL ext_release n=%0d want=1d7", got_q.size()); end
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL ext_release_keys got=%h want=00", keys); end
    send(8'h75);
    settle();
    total++; if (got_q.size() != 3 || got_q[2] !== {8'h75, 2'b00}) begin bad++; $display("FAIL keypad8 n=%0d want=1d4", got_q.size()); end
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL keypad8_keys got=%h want=00", keys); end
  endtask

  task automatic test_fake_shift();
    logic [7:0] seq [10] = '{8'hE0, 8'h12, 8'hE0, 8'h72, 8'hE0, 8'hF0, 8'h72, 8'hE0, 8'hF0, 8'h12};
    got_q.delete();
    for (int i = 0; i < 10; i++) send(seq[i]);
    settle();
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL fake_shift_count got=%0d want=2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== {8'h72, 2'b10} || got_q[1] !== {8'h72, 2'b11}) begin bad++; $display("FAIL fake_shift_events got=%h,%h want=1ca,1cb", got_q[0], got_q[1]); end
    end
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL fake_shift_keys got=%h want=00", keys); end
  endtask

  task automatic test_level_valid();
    got_q.delete();
    @(posedge clk); #1;
    code = 8'h5A; valid = 1'b1;
    repeat (500) @(posedge clk);
    #1 valid = 1'b0;
    settle();
    total++; if (got_q.size() != 1 || got_q[0] !== {8'h5A, 2'b00}) begin bad++; $display("FAIL level_valid n=%0d want one 168", got_q.size()); end
    total++; if (keys !== 8'h20) begin bad++; $display("FAIL level_valid_keys got=%h want=20", keys); end
    send(8'hF0); send(8'h5A);
    settle();
  endtask

  task automatic test_filtering();
    logic [7:0] seq [10] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA, 8'hFA};
    got_q.delete();
    for (int i = 0; i < 10; i++) send(seq[i]);
    settle();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL filter_silent got=%0d events want=0", got_q.size()); end
    send(8'h2E);
    settle();
    total++; if (got_q.size() != 1 || got_q[0] !== {8'h2E, 2'b00}) begin bad++; $display("FAIL filter_after n=%0d want one 0b8", got_q.size()); end
    total++; if (keys !== 8'h40) begin bad++; $display("FAIL filter_keys got=%h want=40", keys); end
    send(8'hF0); send(8'h2E);
    settle();
  endtask

  task automatic test_timeout();
    got_q.delete();
    send(8'hE0);
    repeat (40) @(posedge clk);
    send(8'h74);
    settle();
    total++; if (got_q.size() != 1 || got_q[0] !== {8'h74, 2'b10}) begin bad++; $display("FAIL no_timeout n=%0d want one 1d2", got_q.size()); end
    total++; if (keys !== 8'h08) begin bad++; $display("FAIL no_timeout_keys got=%h want=08", keys); end
    send(8'hE0); send(8'hF0); send(8'h74);
    settle();
    got_q.delete();
    send(8'hE0);
    repeat (TO + 10) @(posedge clk);
    send(8'h74);
    settle();
    total++; if (got_q.size() != 1 || got_q[0] !== {8'h74, 2'b00}) begin bad++; $display("FAIL timeout n=%0d want one 1d0", got_q.size()); end
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL timeout_keys got=%h want=00", keys); end
  endtask

  task automatic test_reset_mid();
    send(8'hE0);
    do_reset();
    send(8'h74);
    settle();
    total++; if (got_q.size() != 1 || got_q[0] !== {8'h74, 2'b00}) begin bad++; $display("FAIL reset_mid n=%0d want one 1d0", got_q.size()); end
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL reset_mid_keys got=%h want=00", keys); end
  endtask

  task automatic test_overflow();
    logic [7:0] presses [4] = '{8'h29, 8'h5A, 8'h2E, 8'h4D};
    logic [9:0] exp [5] = '{{8'h29, 2'b00}, {8'h5A, 2'b00}, {8'h2E, 2'b00}, {8'h4D, 2'b00}, {8'h1C, 2'b00}};
    ev_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) send(presses[i]);
    send(8'hE0); send(8'h6B);
    settle();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    total++; if (ev_valid !== 1'b1 || ev_code !== 8'h29 || ev_ext !== 1'b0 || ev_brk !== 1'b0) begin bad++; $display("FAIL ovf_head got=%b/%h want=1/29", ev_valid, ev_code); end
    total++; if (keys !== 8'hF4) begin bad++; $display("FAIL ovf_keys got=%h want=f4", keys); end
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", overflow); end
    @(posedge clk); #1;
    code = 8'h1C; valid = 1'b1; ev_ready = 1'b1;
    @(posedge clk); #1 ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 valid = 1'b0;
    settle();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_push_pop_ovf got=%b want=0", overflow); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL full_push_pop_pops got=%0d want=1", got_q.size()); end
    ev_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL drain_count got=%0d want=5", got_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (got_q[i] !== exp[i]) begin bad++; $display("FAIL drain_order[%0d] got=%h want=%h", i, got_q[i], exp[i]); end
      end
    end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", ev_valid); end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_extended();
    test_fake_shift();
    test_level_valid();
    test_filtering();
    test_timeout();
    test_reset_mid();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
